// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception / ERET commit controller for the WB stage.
//
// Watches the WB instruction for an interrupt, a synchronous exception or an
// ERET. When one is taken, the pipeline is flushed and the controller steps
// through COMMIT and then REDIRECT:
//   COMMIT   : a one-cycle wb_ex pulse (exception/interrupt) or a one-cycle
//              eret_flush pulse (ERET), with the latched cause info for CP0.
//   REDIRECT : a new fetch PC (EX_ENTRY or EPC) is held until fetch accepts it.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   wb_valid             WB-stage instruction present
//   wb_ex_req            WB instruction raises a synchronous exception
//   wb_exccode_in        ExcCode of that exception
//   wb_eret              WB instruction is ERET
//   wb_pc_in             WB instruction PC
//   wb_bd_in             WB instruction is in a delay slot
//   wb_badvaddr_in       faulting address
//   has_int              pending enabled interrupt
//   cp0_epc              current EPC (ERET target)
//   redirect_ready       fetch accepts the redirect
//   flush                squash all in-flight instructions
//   wb_ex                one-cycle exception commit to CP0
//   wb_exccode, wb_bd,
//   wb_pc, wb_badvaddr   latched cause info to CP0
//   eret_flush           one-cycle ERET commit to CP0
//   redirect_valid       redirect_pc is valid
//   redirect_pc          new fetch PC
//   busy                 controller is not IDLE
//   ex_count             saturating count of committed exceptions/interrupts
module exc_ctrl #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
  parameter logic [4:0]  INT_CODE = 5'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_ex_req,
  input  logic [4:0]  wb_exccode_in,
  input  logic        wb_eret,
  input  logic [31:0] wb_pc_in,
  input  logic        wb_bd_in,
  input  logic [31:0] wb_badvaddr_in,
  input  logic        has_int,
  input  logic [31:0] cp0_epc,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        wb_ex,
  output logic [4:0]  wb_exccode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] ex_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e      state_q;
  logic        armed_q;        // low for the first cycle after reset release
  logic        is_eret_q;
  logic [4:0]  exccode_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] badvaddr_q;
  logic        wb_ex_q;
  logic        eret_flush_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [15:0] ex_count_q;
  logic [15:0] ex_count_d;

  logic        take_s;
  logic        sel_eret_s;
  logic [4:0]  sel_code_s;

  // Take decision and cause priority: interrupt > exception > ERET.
  always_comb begin
    take_s     = 1'b0;
    sel_eret_s = 1'b0;
    sel_code_s = 5'd0;
    if ((state_q == S_IDLE) && armed_q) begin
      take_s = wb_valid & (has_int | wb_ex_req | wb_eret);
    end else begin
      take_s = 1'b0;
    end
    if (has_int) begin
      sel_code_s = INT_CODE;
    end else if (wb_ex_req) begin
      sel_code_s = wb_exccode_in;
    end else begin
      sel_eret_s = 1'b1;
    end
  end

  // Commit counter: wb_ex_q is high exactly during an exception COMMIT cycle.
  always_comb begin
    ex_count_d = ex_count_q;
    if (wb_ex_q && (ex_count_q != 16'hffff)) begin
      ex_count_d = ex_count_q + 16'd1;
    end else begin
      ex_count_d = ex_count_q;
    end
  end

  // Controller FSM with registered commit/redirect outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      armed_q          <= 1'b0;
      is_eret_q        <= 1'b0;
      exccode_q        <= 5'd0;
      pc_q             <= 32'd0;
      bd_q             <= 1'b0;
      badvaddr_q       <= 32'd0;
      wb_ex_q          <= 1'b0;
      eret_flush_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      ex_count_q       <= 16'd0;
    end else begin
      armed_q    <= 1'b1;
      ex_count_q <= ex_count_d;
      case (state_q)
        S_IDLE: begin
          if (take_s) begin
            is_eret_q    <= sel_eret_s;
            exccode_q    <= sel_code_s;
            pc_q         <= wb_pc_in;
            bd_q         <= wb_bd_in;
            badvaddr_q   <= wb_badvaddr_in;
            wb_ex_q      <= ~sel_eret_s;
            eret_flush_q <= sel_eret_s;
            state_q      <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          wb_ex_q          <= 1'b0;
          eret_flush_q     <= 1'b0;
          redirect_pc_q    <= is_eret_q ? cp0_epc : EX_ENTRY;
          redirect_valid_q <= 1'b1;
          state_q          <= S_REDIRECT;
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid_q <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
        default: begin
          wb_ex_q          <= 1'b0;
          eret_flush_q     <= 1'b0;
          redirect_valid_q <= 1'b0;
          state_q          <= S_IDLE;
        end
      endcase
    end
  end

  assign flush          = take_s | (state_q != S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign wb_ex          = wb_ex_q;
  assign eret_flush     = eret_flush_q;
  assign wb_exccode     = exccode_q;
  assign wb_bd          = bd_q;
  assign wb_pc          = pc_q;
  assign wb_badvaddr    = badvaddr_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign ex_count       = ex_count_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  localparam logic [31:0] EX_ENTRY = 32'hbfc00380;
  localparam logic [4:0]  INT_CODE = 5'h00;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0, wb_ex_req = 1'b0, wb_eret = 1'b0, wb_bd_in = 1'b0;
  logic [4:0]  wb_exccode_in = 5'd0;
  logic [31:0] wb_pc_in = 32'd0, wb_badvaddr_in = 32'd0, cp0_epc = 32'd0;
  logic        has_int = 1'b0, redirect_ready = 1'b0;
  logic        flush, wb_ex, wb_bd, eret_flush, redirect_valid, busy;
  logic [4:0]  wb_exccode;
  logic [31:0] wb_pc, wb_badvaddr, redirect_pc;
  logic [15:0] ex_count;

  int n_chk = 0;
  int n_pass = 0;
  int count_exp = 0;   // reference: committed exceptions, saturating at 65535

  exc_ctrl #(.EX_ENTRY(EX_ENTRY), .INT_CODE(INT_CODE)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ex_req(wb_ex_req),
    .wb_exccode_in(wb_exccode_in), .wb_eret(wb_eret), .wb_pc_in(wb_pc_in),
    .wb_bd_in(wb_bd_in), .wb_badvaddr_in(wb_badvaddr_in), .has_int(has_int),
    .cp0_epc(cp0_epc), .redirect_ready(redirect_ready), .flush(flush),
    .wb_ex(wb_ex), .wb_exccode(wb_exccode), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .ex_count(ex_count)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    wb_valid = 1'b0; wb_ex_req = 1'b0; wb_eret = 1'b0; has_int = 1'b0;
    redirect_ready = 1'b0;
  endtask

  task automatic garbage_inputs();
    wb_valid = 1'b1; wb_ex_req = 1'($urandom_range(0, 1)); has_int = 1'($urandom_range(0, 1));
    wb_eret = 1'b1; wb_exccode_in = 5'($urandom); wb_pc_in = $urandom;
  endtask

  // One WB-stage event followed through take, commit, redirect and return.
  task automatic run_txn(input logic v, input logic intr, input logic exr, input logic er,
                         input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [31:0] bva, input logic [31:0] epc, input int delay);
    logic exp_take, exp_eret;
    logic [4:0] exp_code;
    logic [31:0] exp_tgt;
    exp_take = v && (intr || exr || er);
    exp_eret = !intr && !exr && er;
    exp_code = intr ? INT_CODE : code;
    exp_tgt  = exp_eret ? epc : EX_ENTRY;

    @(negedge clk);
    wb_valid = v; has_int = intr; wb_ex_req = exr; wb_eret = er; wb_exccode_in = code;
    wb_pc_in = pc; wb_bd_in = bd; wb_badvaddr_in = bva; cp0_epc = epc;
    redirect_ready = 1'($urandom_range(0, 1));
    #1;
    n_chk++; if (flush !== exp_take) $display("FAIL take_flush: got %b exp %b", flush, exp_take); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy); else n_pass++;

    @(negedge clk);
    if (!exp_take) begin
      n_chk++; if (busy !== 1'b0) $display("FAIL no_take_busy: got %b exp 0", busy); else n_pass++;
      n_chk++; if (wb_ex !== 1'b0 || eret_flush !== 1'b0)
        $display("FAIL no_take_pulse: got %b%b exp 00", wb_ex, eret_flush); else n_pass++;
      clear_inputs();
      return;
    end
    n_chk++; if (wb_ex !== !exp_eret) $display("FAIL commit_wb_ex: got %b exp %b", wb_ex, !exp_eret); else n_pass++;
    n_chk++; if (eret_flush !== exp_eret) $display("FAIL commit_eret: got %b exp %b", eret_flush, exp_eret); else n_pass++;
    n_chk++; if (busy !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b0)
      $display("FAIL commit_flags: got busy %b flush %b rv %b exp 1 1 0", busy, flush, redirect_valid); else n_pass++;
    n_chk++; if (wb_pc !== pc || wb_bd !== bd || wb_badvaddr !== bva)
      $display("FAIL commit_info: got %h %b %h exp %h %b %h", wb_pc, wb_bd, wb_badvaddr, pc, bd, bva); else n_pass++;
    if (!exp_eret) begin
      n_chk++; if (wb_exccode !== exp_code) $display("FAIL commit_code: got %h exp %h", wb_exccode, exp_code); else n_pass++;
      if (count_exp < 65535) count_exp++;
    end
    // Causes and early ready are ignored while busy; cp0_epc must still hold.
    garbage_inputs();
    redirect_ready = 1'($urandom_range(0, 1));

    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      n_chk++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_tgt)
        $display("FAIL redirect_hold[%0d]: got %b %h exp 1 %h", i, redirect_valid, redirect_pc, exp_tgt); else n_pass++;
      n_chk++; if (wb_ex !== 1'b0 || eret_flush !== 1'b0 || busy !== 1'b1 || flush !== 1'b1)
        $display("FAIL redirect_flags[%0d]: got %b%b%b%b exp 0011", i, wb_ex, eret_flush, busy, flush); else n_pass++;
      cp0_epc = $urandom;
      if (i == delay) begin
        clear_inputs();
        redirect_ready = 1'b1;
      end else begin
        garbage_inputs();
        redirect_ready = 1'b0;
      end
    end
    @(negedge clk);
    redirect_ready = 1'b0;
    n_chk++; if (busy !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL return_idle: got busy %b rv %b exp 0 0", busy, redirect_valid); else n_pass++;
    n_chk++; if (ex_count !== 16'(count_exp)) $display("FAIL ex_count: got %0d exp %0d", ex_count, count_exp); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (flush !== 1'b0 || wb_ex !== 1'b0 || eret_flush !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctrl: got %b%b%b%b%b exp 00000", flush, wb_ex, eret_flush, redirect_valid, busy); else n_pass++;
    n_chk++; if (ex_count !== 16'd0 || redirect_pc !== 32'd0 || wb_pc !== 32'd0 || wb_exccode !== 5'd0 || wb_badvaddr !== 32'd0)
      $display("FAIL reset_data: got %h %h %h %h %h exp 0", ex_count, redirect_pc, wb_pc, wb_exccode, wb_badvaddr); else n_pass++;
    resetn = 1'b1;
    count_exp = 0;
  endtask

  // Causes already present at release must not flush in the first cycle.
  task automatic test_reset_release();
    @(negedge clk);
    resetn = 1'b0; wb_valid = 1'b1; has_int = 1'b1; wb_ex_req = 1'b1;
    #1;
    n_chk++; if (flush !== 1'b0) $display("FAIL in_reset_flush: got %b exp 0", flush); else n_pass++;
    @(negedge clk);
    resetn = 1'b1; count_exp = 0;
    #1;
    n_chk++; if (flush !== 1'b0 || wb_ex !== 1'b0 || eret_flush !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL release_cycle: got %b%b%b%b exp 0000", flush, wb_ex, eret_flush, redirect_valid); else n_pass++;
    @(negedge clk);
    clear_inputs();
    n_chk++; if (busy !== 1'b0) $display("FAIL release_no_take: got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_syscall();
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 5'h08, 32'hbfc00100, 1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_int_priority();
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 5'h04, 32'hbfc00140, 1'b1, 32'h1234_5678, 32'h0, 1);
  endtask

  task automatic test_eret();
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 5'h0a, 32'hbfc00180, 1'b0, 32'h0, 32'hbfc00200, 0);
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 5'h0c, 32'h8000_0040, 1'b1, 32'hdead_beef, 32'h0, 5);
  endtask

  task automatic test_no_valid();
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b1, 5'h05, 32'h4, 1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
              5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.ex_count_q = 16'hfffe;
    @(negedge clk);
    release dut.ex_count_q;
    count_exp = 65534;
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 5'h0d, 32'h100, 1'b0, 32'h0, 32'h0, 0);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 32'h104, 1'b0, 32'h0, 32'h0, 0);
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 5'h0e, 32'h108, 1'b0, 32'h0, 32'h0, 1);
  endtask

  // Reset dropped in COMMIT (k=0) and in REDIRECT (k=1).
  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_ex_req = 1'b1; wb_exccode_in = 5'h08; wb_pc_in = 32'hbfc00300;
      @(negedge clk);
      clear_inputs();
      if (k == 1) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      n_chk++; if (busy !== 1'b0 || flush !== 1'b0 || wb_ex !== 1'b0 || redirect_valid !== 1'b0)
        $display("FAIL mid_reset_ctrl[%0d]: got %b%b%b%b exp 0000", k, busy, flush, wb_ex, redirect_valid); else n_pass++;
      n_chk++; if (ex_count !== 16'd0 || redirect_pc !== 32'd0 || wb_pc !== 32'd0)
        $display("FAIL mid_reset_data[%0d]: got %h %h %h exp 0", k, ex_count, redirect_pc, wb_pc); else n_pass++;
      @(negedge clk);
      resetn = 1'b1; count_exp = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_chk++; if (wb_ex !== 1'b0 || eret_flush !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0)
          $display("FAIL post_reset[%0d.%0d]: got %b%b%b%b exp 0000", k, c, wb_ex, eret_flush, redirect_valid, busy); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_syscall();
    test_int_priority();
    test_eret();
    test_backpressure();
    test_no_valid();
    test_random();
    test_saturation();
    test_reset_mid();
    test_syscall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EX_ENTRY, default 32'hbfc00380, the exception vector (BEV=1).
REQ-002 SHALL have parameter INT_CODE, default 5'h00, the ExcCode for interrupts.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock, all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- wb_valid  in  1  a WB-stage instruction is present this cycle.
- wb_ex_req  in  1  the WB instruction carries a synchronous exception.
- wb_exccode_in  in  5  ExcCode of that exception.
- wb_eret  in  1  the WB instruction is ERET.
- wb_pc_in  in  32  WB instruction PC.
- wb_bd_in  in  1  the WB instruction is in a delay slot.
- wb_badvaddr_in  in  32  faulting address.
- has_int  in  1  pending enabled interrupt from CP0.
- cp0_epc  in  32  current EPC value.
- redirect_ready  in  1  fetch accepts the redirect.
- flush  out  1  squash all in-flight instructions.
- wb_ex  out  1  one-cycle exception commit to CP0.
- wb_exccode  out  5  ExcCode to CP0.
- wb_bd  out  1  delay-slot flag to CP0.
- wb_pc  out  32  PC to CP0.
- wb_badvaddr  out  32  BadVAddr to CP0.
- eret_flush  out  1  one-cycle ERET commit to CP0.
- redirect_valid  out  1  new fetch PC is valid.
- redirect_pc  out  32  new fetch PC.
- busy  out  1  the controller is not IDLE.
- ex_count  out  16  saturating count of committed exceptions and interrupts.

Function
REQ-004 SHALL implement FSM states IDLE, COMMIT and REDIRECT.
REQ-005 SHALL define take = wb_valid & (has_int | wb_ex_req | wb_eret), evaluated only in IDLE.
REQ-006 SHALL prioritise causes as has_int > wb_ex_req > wb_eret; an interrupt uses ExcCode INT_CODE.
REQ-007 On take in IDLE, SHALL latch cause, exccode, pc, bd, badvaddr and the kind (exception or eret), and go to COMMIT on the next edge.
REQ-008 In COMMIT, SHALL assert wb_ex=1 for exactly one cycle for an exception or interrupt, or eret_flush=1 for exactly one cycle for an ERET; never both.
REQ-009 In COMMIT, SHALL drive wb_exccode, wb_bd, wb_pc and wb_badvaddr from the latched values.
REQ-010 In COMMIT, SHALL latch redirect_pc as EX_ENTRY for an exception, or as cp0_epc for an ERET, then go to REDIRECT.
REQ-011 In REDIRECT, SHALL hold redirect_valid=1 and redirect_pc stable until redirect_ready=1, then return to IDLE on that edge.
REQ-012 SHALL drive flush combinationally: flush = (IDLE & take) | COMMIT | REDIRECT.
REQ-013 SHALL drive busy=1 exactly when the state is not IDLE; wb_valid and all causes SHALL be ignored while busy.
REQ-014 SHALL assert redirect_valid only in REDIRECT; redirect_ready outside REDIRECT has no effect.
REQ-015 If redirect_ready=1 on the first REDIRECT cycle, SHALL return to IDLE after exactly one REDIRECT cycle; the IDLE-to-IDLE turnaround is 3 cycles minimum.
REQ-016 SHALL increment ex_count by 1 in each COMMIT cycle with wb_ex=1 and saturate at 16'hffff; ERET SHALL NOT count.
REQ-017 When wb_valid=0, has_int alone SHALL NOT take.

Reset
REQ-018 On resetn=0, asynchronously and at any state, SHALL set state=IDLE, ex_count=0, and all latched values, redirect_pc and outputs to 0.
REQ-019 While resetn=0 and in the first cycle after release, SHALL hold flush, wb_ex, eret_flush and redirect_valid at 0.
REQ-020 Reset asserted mid-COMMIT or mid-REDIRECT SHALL abort with no wb_ex or eret_flush pulse after release.

Verification
REQ-021 Syscall: wb_valid=1, wb_ex_req=1, code 5'h08, pc 32'hbfc00100, bd=0 -> flush same cycle; next cycle wb_ex=1, wb_exccode=8, wb_pc=32'hbfc00100; then redirect_valid=1 with redirect_pc=32'hbfc00380; ex_count=1.
REQ-022 Interrupt and exception together: has_int=1 with wb_ex_req=1, code 5'h04 -> wb_exccode=0; exactly one wb_ex pulse.
REQ-023 ERET: wb_eret=1, cp0_epc=32'hbfc00200 -> eret_flush pulse only, redirect_pc=32'hbfc00200, ex_count unchanged.
REQ-024 Backpressure: hold redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stable; a new wb_ex_req during this time is ignored; IDLE one edge after redirect_ready=1.
REQ-025 Saturation: preload 65535 commits, then one more exception -> ex_count stays 16'hffff.
REQ-026 Reset in COMMIT: drop resetn during COMMIT -> state=IDLE, outputs 0, no pulse after release.
